dmem_handshake: RTL and testbench
=================================

Name: dmem_handshake

Overview:
- Multi-cycle data-memory responder in the MEM stage. It generates the Done_DM completion signal that the pipeline's stall logic consumes.
- Accepts one load/store at a time and holds Done low for a fixed latency so the pipeline inserts NOPs.
- Asserts Done with read data for exactly one cycle, then returns to idle.
- Done is high whenever no access is in flight, so non-memory instructions never stall.

Parameters:
- ADDR_W, 10, byte-address bits used; array holds 2^(ADDR_W-1) 16-bit words.
- LATENCY, 4, cycles from request-accept cycle to Done cycle; legal range 2..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Rd  input  1  load request from MEM stage.
- Wr  input  1  store request from MEM stage.
- Addr  input  16  byte address; word index = Addr[ADDR_W-1:1].
- DataIn  input  16  store data.
- DataOut  output  16  load data, registered.
- Done  output  1  high = no access pending or access completing this cycle.
- Busy  output  1  high while an accepted access is in flight (BUSY state).

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values: state IDLE, counter 0, DataOut 16'h0000, latched request cleared. Outputs after reset: Done=1, Busy=0. Memory array is not reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Done = ~(Rd|Wr), Busy = 0.
  - If Rd|Wr at a rising edge: latch Addr, DataIn and op, load counter with LATENCY-2, go to BUSY.
  - Wr has priority when Rd and Wr are both high (treated as a store).
- BUSY:
  - Done = 0, Busy = 1. Request inputs are ignored; the pipeline holds them stable.
  - Counter decrements each edge. At counter==0: go to DONE.
    - Store: commit the latched data to the array on that same edge.
    - Load: DataOut <= array[latched index] on that same edge.
- DONE:
  - Done = 1, Busy = 0, for exactly one cycle; the pipeline advances at this edge.
  - Request inputs in this cycle are ignored (they are the completing instruction's).
  - Next state is IDLE.
- Latency: request present in cycle 0, Done=0 in cycles 0..LATENCY-1, Done=1 in cycle LATENCY.
  - Back-to-back accesses: minimum spacing is LATENCY+1 cycles.
- DataOut holds its value until the next load completes; stores do not alter it.
- Reset mid-access: the access aborts, a pending store is not committed, and the FSM returns to IDLE.
- Word-index wrap: address bits above ADDR_W-1 are ignored (aliasing).

Optional Feature:
- Macro DMEM_ALIGN_ERR_EN.
- Defined:
  - Adds output port Err (1 bit), reset 0.
  - An accepted access with Addr[0]=1 still takes the full latency. Err=1 during its DONE cycle, the store is suppressed, and DataOut is forced to 16'h0000. Err=0 in all other cycles.
- Undefined: no Err port; Addr[0] is ignored and the access is word-aligned silently.

Decomposition:
- Shared package dmem_pkg: state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), LATENCY_MIN=2, LATENCY_MAX=15, WORD_W=16.
- One sub-module, dmem_array: synchronous-write, registered-read word array with ports clk, we, windex, wdata, rindex, re, rdata. The FSM stays in dmem_handshake.

Test Plan:
- Reset idle: assert rst mid-cycle, release -> Done=1, Busy=0, DataOut=0; hold Rd=Wr=0 for 5 cycles -> Done stays 1.
- Store then load, LATENCY=4:
  - Wr with Addr=16'h0010, DataIn=16'hBEEF -> Done low for cycles 0..3 and high in cycle 4.
  - Then Rd with Addr=16'h0010 -> DataOut=16'hBEEF in its cycle 4, with Done=1 that cycle.
- Rd and Wr together, Addr=16'h0020, DataIn=16'h1234 -> treated as a store; a later read of 16'h0020 returns 16'h1234.
- Reset during BUSY: Wr to 16'h0030, data 16'hAAAA (location pre-written with 16'h5555); pulse rst in cycle 2 -> FSM IDLE, Done=1; a later read returns 16'h5555.
- Input changes during BUSY: change Addr and DataIn every cycle while Busy=1 -> the original latched values are used.
- DMEM_ALIGN_ERR_EN: Wr with Addr=16'h0041, DataIn=16'hFFFF -> Err=1 only in the DONE cycle, no write; a later read of 16'h0040 returns its old value.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// dmem_pkg: shared state encoding and constants for the data-memory handshake responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int LATENCY_MIN = 2;
  localparam int LATENCY_MAX = 15;
  localparam int WORD_W      = 16;

  // Counter preload: the accept edge and the DONE transition edge consume two of the latency cycles.
  function automatic logic [3:0] cnt_init(input int lat);
    return 4'(lat - LATENCY_MIN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// dmem_array: word array with synchronous write and registered read.
module dmem_array #(
  parameter int IDX_W  = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  windex,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  rindex,
  input  logic              re,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[windex] <= wdata;
    if (re) rdata_q <= mem_q[rindex];
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_handshake.sv
`default_nettype none
// dmem_handshake: fixed-latency MEM-stage data memory producing the Done_DM stall handshake.
// Optional macro DMEM_ALIGN_ERR_EN adds the Err output and suppresses misaligned accesses.
module dmem_handshake
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Busy
`ifdef DMEM_ALIGN_ERR_EN
  ,
  output logic        Err
`endif
);

  localparam int         IDX_W    = ADDR_W - 1;
  localparam logic [3:0] CNT_INIT = cnt_init(LATENCY);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                store_q, store_d;
  logic                mis_q, mis_d;
  logic                zero_q, zero_d;
  logic                finish;
  logic                arr_we;
  logic                arr_re;
  logic [WORD_W-1:0]   arr_rdata;

`ifdef DMEM_ALIGN_ERR_EN
  logic err_q, err_d;
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr[15:ADDR_W];
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Addr[15:ADDR_W], Addr[0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    store_d = store_q;
    mis_d   = mis_q;
    zero_d  = zero_q;
    finish  = (state_q == ST_BUSY) && (cnt_q == 4'd0);

    unique case (state_q)
      ST_IDLE: begin
        if (Rd || Wr) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_INIT;
          idx_d   = Addr[ADDR_W-1:1];
          wdata_d = DataIn;
          store_d = Wr;
`ifdef DMEM_ALIGN_ERR_EN
          mis_d   = Addr[0];
`else
          mis_d   = 1'b0;
`endif
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A completing load either exposes the array read or, when misaligned, forces zero.
    if (finish && !store_q) zero_d = mis_q;

    arr_we = finish && store_q && !mis_q;
    arr_re = finish && !store_q && !mis_q;

    Busy = (state_q == ST_BUSY);
    Done = (state_q == ST_IDLE) ? !(Rd || Wr) : (state_q == ST_DONE);
  end

`ifdef DMEM_ALIGN_ERR_EN
  always_comb begin
    err_d = finish && mis_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      mis_q   <= 1'b0;
      zero_q  <= 1'b1;
`ifdef DMEM_ALIGN_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      store_q <= store_d;
      mis_q   <= mis_d;
      zero_q  <= zero_d;
`ifdef DMEM_ALIGN_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  dmem_array #(
    .IDX_W  (IDX_W),
    .DATA_W (WORD_W)
  ) u_array (
    .clk    (clk),
    .we     (arr_we),
    .windex (idx_q),
    .wdata  (wdata_q),
    .rindex (idx_q),
    .re     (arr_re),
    .rdata  (arr_rdata)
  );

  // The array read register has no reset, so a flag masks it until the first good load.
  assign DataOut = zero_q ? 16'h0000 : arr_rdata;

`ifdef DMEM_ALIGN_ERR_EN
  assign Err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_handshake.sv
`default_nettype none
// tb_dmem_handshake: directed self-checking bench for dmem_handshake with LATENCY=4.
module tb_dmem_handshake;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        Rd;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Done;
  logic        Busy;
`ifdef DMEM_ALIGN_ERR_EN
  logic        Err;
  logic        exp_err;
`endif

  int checks = 0;
  int errors = 0;

  dmem_handshake #(
    .ADDR_W  (10),
    .LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Rd      (Rd),
    .Wr      (Wr),
    .Addr    (Addr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Done    (Done),
    .Busy    (Busy)
`ifdef DMEM_ALIGN_ERR_EN
    ,
    .Err     (Err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access from request cycle 0 through the DONE cycle LAT, checking handshake every cycle.
  task automatic access(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] din, input logic [15:0] exp_dout,
                        input logic scramble);
    @(posedge clk);
    #1;
    Rd = rd; Wr = wr; Addr = addr; DataIn = din;
    for (int c = 0; c <= LAT; c++) begin
      @(negedge clk);
      if (c < LAT) begin
        check("done_low", {15'd0, Done}, 16'd0);
        check("busy", {15'd0, Busy}, (c == 0) ? 16'd0 : 16'd1);
      end else begin
        check("done_high", {15'd0, Done}, 16'd1);
        check("busy_done", {15'd0, Busy}, 16'd0);
        check("dataout", DataOut, exp_dout);
      end
`ifdef DMEM_ALIGN_ERR_EN
      check("err", {15'd0, Err}, {15'd0, exp_err && (c == LAT)});
`endif
      if (scramble && c >= 1 && c < LAT) begin
        Addr   = 16'($urandom);
        DataIn = 16'($urandom);
      end
    end
    @(posedge clk);
    #1;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Rd = 1'b0; Wr = 1'b0; Addr = 16'h0000; DataIn = 16'h0000;
`ifdef DMEM_ALIGN_ERR_EN
    exp_err = 1'b0;
`endif
    #12;
    check("rst_done", {15'd0, Done}, 16'd1);
    check("rst_busy", {15'd0, Busy}, 16'd0);
    check("rst_dout", DataOut, 16'h0000);
    #5 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_done", {15'd0, Done}, 16'd1);
      check("idle_busy", {15'd0, Busy}, 16'd0);
    end

    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    access(1'b1, 1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0);
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0);
    access(1'b0, 1'b1, 16'h0030, 16'h5555, 16'h1234, 1'b0);

    // Abort a store with reset in cycle 2 of the access.
    @(posedge clk);
    #1;
    Wr = 1'b1; Addr = 16'h0030; DataIn = 16'hAAAA;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort_busy_pre", {15'd0, Busy}, 16'd1);
    Wr = 1'b0; rst = 1'b1;
    #1;
    check("abort_busy", {15'd0, Busy}, 16'd0);
    check("abort_done", {15'd0, Done}, 16'd1);
    check("abort_dout", DataOut, 16'h0000);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_idle", {15'd0, Done}, 16'd1);
    access(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h5555, 1'b0);

    access(1'b0, 1'b1, 16'h0050, 16'hCAFE, 16'h5555, 1'b1);
    access(1'b1, 1'b0, 16'h0050, 16'h0000, 16'hCAFE, 1'b1);
    // Address bit 10 lies above the index field and aliases onto 0x0050.
    access(1'b1, 1'b0, 16'h0450, 16'h0000, 16'hCAFE, 1'b0);

    access(1'b0, 1'b1, 16'h0040, 16'h7777, 16'hCAFE, 1'b0);
`ifdef DMEM_ALIGN_ERR_EN
    exp_err = 1'b1;
    access(1'b0, 1'b1, 16'h0041, 16'hFFFF, 16'hCAFE, 1'b0);
    exp_err = 1'b0;
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h7777, 1'b0);
    exp_err = 1'b1;
    access(1'b1, 1'b0, 16'h0041, 16'h0000, 16'h0000, 1'b0);
    exp_err = 1'b0;
`else
    access(1'b0, 1'b1, 16'h0041, 16'hFFFF, 16'hCAFE, 1'b0);
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hFFFF, 1'b0);
`endif

    @(negedge clk);
    check("final_done", {15'd0, Done}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
